// File: rtl/layer_seq_ctrl.sv
// Layer sequencer: issues one node per cycle to a shared pipelined neuron
// datapath, captures the tagged results into out_vec and pulses done.
module layer_seq_ctrl #(
  parameter int NUM_NODES = 4,
  parameter int IDX_W     = 2,
  parameter int DP_LAT    = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   abort,
  output logic                   dp_en,
  output logic [IDX_W-1:0]       dp_sel,
  input  logic [7:0]             dp_result,
  output logic [8*NUM_NODES-1:0] out_vec,
  output logic                   busy,
  output logic                   done,
  output logic                   start_overrun
);

  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_FIN} state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NODES - 1);

  state_t           state_reg;
  logic [DP_LAT-1:0] tag_valid;
  logic [IDX_W-1:0] tag_idx [DP_LAT];
  logic             flush;
  logic             drain_clear;
  logic             tag_exit;
  logic [IDX_W-1:0] exit_idx;

  assign flush    = abort && (state_reg != ST_IDLE);
  assign tag_exit = tag_valid[DP_LAT-1];
  assign exit_idx = tag_idx[DP_LAT-1];

  // The exiting stage is consumed this edge, so only the earlier stages decide emptiness.
  always_comb begin
    drain_clear = 1'b1;
    for (int i = 0; i < DP_LAT - 1; i++) begin
      if (tag_valid[i]) drain_clear = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tag_valid <= '0;
      for (int i = 0; i < DP_LAT; i++) tag_idx[i] <= '0;
    end else begin
      for (int i = DP_LAT - 1; i >= 1; i--) begin
        tag_valid[i] <= tag_valid[i-1];
        tag_idx[i]   <= tag_idx[i-1];
      end
      tag_valid[0] <= dp_en;
      tag_idx[0]   <= dp_sel;
      if (flush) tag_valid <= '0;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NUM_NODES; gi++) begin : g_slice
      logic [7:0] slice_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          slice_reg <= 8'h00;
        end else if (tag_exit && (exit_idx == IDX_W'(gi))) begin
          slice_reg <= dp_result;
        end
      end
      assign out_vec[8*gi +: 8] = slice_reg;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= ST_IDLE;
      dp_en         <= 1'b0;
      dp_sel        <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      start_overrun <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start && (state_reg != ST_IDLE)) start_overrun <= 1'b1;
      case (state_reg)
        ST_IDLE: begin
          if (start && !abort) begin
            state_reg     <= ST_ISSUE;
            dp_en         <= 1'b1;
            dp_sel        <= '0;
            busy          <= 1'b1;
            start_overrun <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            dp_en     <= 1'b0;
            dp_sel    <= '0;
            busy      <= 1'b0;
          end else if (dp_sel == LAST_IDX) begin
            state_reg <= ST_DRAIN;
            dp_en     <= 1'b0;
            dp_sel    <= '0;
          end else begin
            dp_sel <= dp_sel + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
          end else if (drain_clear) begin
            state_reg <= ST_FIN;
            busy      <= 1'b0;
            done      <= 1'b1;
          end
        end
        ST_FIN: begin
          state_reg <= ST_IDLE;
        end
        default: begin
          state_reg <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
